// File: rtl/hpu_pkg.sv
// Shared types and helpers for the hypervector processing unit.
package hpu_pkg;

  // Width of one beat on the output stream toward the DMA.
  localparam int WORD_W = 32;

  // Output serializer states.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } hv_out_state_t;

  // Beats needed to carry a hypervector whose MSB index is dim.
  function automatic int calc_nwords(input int dim);
    return (dim + 1) / WORD_W;
  endfunction

endpackage

// File: rtl/hv_stream_out.sv
// Hypervector output serializer: snapshots the binarized sign vector on start
// and streams it out as WORD_W-bit beats with valid/ready flow control.
module hv_stream_out
  import hpu_pkg::*;
#(
  parameter int DIM = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIM:0]      sign_bit,
  input  logic              start,
  output logic              dst_valid,
  input  logic              dst_ready,
  output logic [WORD_W-1:0] dst_data,
  output logic              dst_last,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int NWORDS = calc_nwords(DIM);
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  // The vector must split into whole beats; stop elaboration otherwise.
  if (((DIM + 1) % WORD_W) != 0) begin : g_bad_dim
    $error("hv_stream_out: DIM+1 (%0d) must be a multiple of %0d", DIM + 1, WORD_W);
  end

  hv_out_state_t                   state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d, idx_inc;
  logic [NWORDS-1:0][WORD_W-1:0]   shadow_q;
  logic [WORD_W-1:0]               data_q, data_d;
  logic                            last_q, last_d;
  logic                            done_q, done_d;
  logic                            overrun_q, overrun_d;
  logic                            hs, final_hs, accept;

  // Next-state and next-output decode; every output is registered so
  // dst_ready never reaches dst_valid or dst_data combinationally.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    last_d    = last_q;
    hs        = (state_q == SEND) && dst_ready;
    final_hs  = hs && last_q;
    accept    = start && ((state_q == IDLE) || final_hs);
    idx_inc   = idx_q + 1'b1;
    done_d    = final_hs;
    overrun_d = start && !accept;

    if (accept) begin
      // New vector: word 0 comes straight from the input since the shadow
      // copy only lands at this same edge.
      state_d = SEND;
      idx_d   = '0;
      data_d  = sign_bit[WORD_W-1:0];
      last_d  = (NWORDS == 1);
    end else if (final_hs) begin
      state_d = IDLE;
      data_d  = '0;
      last_d  = 1'b0;
    end else if (hs) begin
      idx_d  = idx_inc;
      data_d = shadow_q[idx_inc];
      last_d = (idx_inc == LAST_IDX);
    end
  end

  // Control and output registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      last_q    <= last_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  // Snapshot of the sign vector taken on every accepted start.
  always_ff @(posedge clk) begin
    // NOTE: the wide shadow register has no reset; it is always loaded before it is read.
    if (accept) shadow_q <= sign_bit;
  end

  assign dst_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign dst_data  = data_q;
  assign dst_last  = last_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_hv_stream_out.sv
// Self-checking bench for hv_stream_out: directed scenarios plus randomized
// vectors with random backpressure, checked against a word-slice model.
module tb_hv_stream_out;
  import hpu_pkg::*;

  localparam int DIM = 1023;
  localparam int NW  = (DIM + 1) / 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [DIM:0]   sign_bit;
  logic           start;
  logic           dst_valid;
  logic           dst_ready;
  logic [31:0]    dst_data;
  logic           dst_last;
  logic           busy;
  logic           done;
  logic           overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hv_stream_out #(.DIM(DIM)) dut (
    .clk       (clk),
    .rst       (rst),
    .sign_bit  (sign_bit),
    .start     (start),
    .dst_valid (dst_valid),
    .dst_ready (dst_ready),
    .dst_data  (dst_data),
    .dst_last  (dst_last),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DIM:0] pattern_vec(input logic [31:0] base);
    logic [DIM:0] v;
    for (int k = 0; k < NW; k++) v[32*k +: 32] = base | 32'(k);
    return v;
  endfunction

  function automatic logic [DIM:0] random_vec();
    logic [DIM:0] v;
    for (int k = 0; k < NW; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  // Reference: beat k carries bits [32k+31:32k] of the snapshotted vector.
  function automatic logic [31:0] word_of(input logic [DIM:0] v, input int k);
    return v[32*k +: 32];
  endfunction

  // Pulse start with vec for one edge, then scramble sign_bit.
  task automatic launch(input logic [DIM:0] vec);
    sign_bit = vec;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    sign_bit = random_vec();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dst_ready = 1'b1; sign_bit = random_vec();
    tick(); tick();
    checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL reset valid got=%b exp=0", dst_valid); end
    checks++; if (dst_data !== 32'h0) begin errors++; $display("FAIL reset data got=%h exp=0", dst_data); end
    checks++; if (dst_last !== 1'b0) begin errors++; $display("FAIL reset last got=%b exp=0", dst_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done got=%b exp=0", done); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset overrun got=%b exp=0", overrun); end
    rst = 1'b0;
    tick();
    checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL post_reset valid got=%b exp=0", dst_valid); end
  endtask

  task automatic test_full_rate();
    logic [DIM:0] v;
    v = pattern_vec(32'hA500_0000);
    dst_ready = 1'b1;
    launch(v);
    for (int k = 0; k < NW; k++) begin
      checks++; if (dst_valid !== 1'b1) begin errors++; $display("FAIL full_rate valid k=%0d got=%b exp=1", k, dst_valid); end
      checks++; if (dst_data !== word_of(v, k)) begin errors++; $display("FAIL full_rate data k=%0d got=%h exp=%h", k, dst_data, word_of(v, k)); end
      checks++; if (dst_last !== (k == NW - 1)) begin errors++; $display("FAIL full_rate last k=%0d got=%b exp=%b", k, dst_last, (k == NW - 1)); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_rate early_done k=%0d got=%b exp=0", k, done); end
      tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_rate done got=%b exp=1", done); end
    checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL full_rate idle_valid got=%b exp=0", dst_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_rate idle_busy got=%b exp=0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_rate done_width got=%b exp=0", done); end
  endtask

  task automatic test_backpressure();
    logic [DIM:0] v;
    int k, cyc;
    logic ph;
    v = pattern_vec(32'hA500_0000);
    dst_ready = 1'b1;
    launch(v);
    k = 0; cyc = 0; ph = 1'b1;
    while (k < NW && cyc < 200) begin
      checks++; if (dst_valid !== 1'b1) begin errors++; $display("FAIL backpressure valid cyc=%0d got=%b exp=1", cyc, dst_valid); end
      checks++; if (dst_data !== word_of(v, k)) begin errors++; $display("FAIL backpressure data cyc=%0d got=%h exp=%h", cyc, dst_data, word_of(v, k)); end
      checks++; if (dst_last !== (k == NW - 1)) begin errors++; $display("FAIL backpressure last cyc=%0d got=%b exp=%b", cyc, dst_last, (k == NW - 1)); end
      dst_ready = ph;
      ph = ~ph;
      if (dst_valid && dst_ready) k++;
      cyc++;
      tick();
    end
    checks++; if (cyc !== 2 * NW - 1) begin errors++; $display("FAIL backpressure cycles got=%0d exp=%0d", cyc, 2 * NW - 1); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL backpressure done got=%b exp=1", done); end
    checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL backpressure idle_valid got=%b exp=0", dst_valid); end
    dst_ready = 1'b1;
    tick();
  endtask

  task automatic test_overrun();
    logic [DIM:0] a, b;
    a = pattern_vec(32'hA500_0000);
    b = pattern_vec(32'h3C00_0000);
    dst_ready = 1'b1;
    launch(a);
    for (int k = 0; k < NW; k++) begin
      checks++; if (dst_data !== word_of(a, k)) begin errors++; $display("FAIL overrun data k=%0d got=%h exp=%h", k, dst_data, word_of(a, k)); end
      checks++; if (overrun !== (k == 6)) begin errors++; $display("FAIL overrun pulse k=%0d got=%b exp=%b", k, overrun, (k == 6)); end
      checks++; if (dst_last !== (k == NW - 1)) begin errors++; $display("FAIL overrun last k=%0d got=%b exp=%b", k, dst_last, (k == NW - 1)); end
      start = (k == 5);
      if (k == 5) sign_bit = b;
      tick();
    end
    start = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL overrun done got=%b exp=1", done); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL overrun extra_beat i=%0d got=%b exp=0", i, dst_valid); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [DIM:0] a, b;
    a = pattern_vec(32'hA500_0000);
    b = pattern_vec(32'h5A00_0000);
    dst_ready = 1'b1;
    launch(a);
    for (int k = 0; k < NW; k++) begin
      checks++; if (dst_data !== word_of(a, k)) begin errors++; $display("FAIL b2b first_data k=%0d got=%h exp=%h", k, dst_data, word_of(a, k)); end
      if (k == NW - 1) begin
        start = 1'b1;
        sign_bit = b;
      end
      tick();
    end
    start = 1'b0;
    sign_bit = random_vec();
    checks++; if (dst_valid !== 1'b1) begin errors++; $display("FAIL b2b bubble_valid got=%b exp=1", dst_valid); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b done got=%b exp=1", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b busy got=%b exp=1", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b overrun got=%b exp=0", overrun); end
    for (int k = 0; k < NW; k++) begin
      checks++; if (dst_data !== word_of(b, k)) begin errors++; $display("FAIL b2b second_data k=%0d got=%h exp=%h", k, dst_data, word_of(b, k)); end
      checks++; if (dst_last !== (k == NW - 1)) begin errors++; $display("FAIL b2b second_last k=%0d got=%b exp=%b", k, dst_last, (k == NW - 1)); end
      tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b second_done got=%b exp=1", done); end
    tick();
  endtask

  task automatic test_reset_midstream();
    logic [DIM:0] a, c;
    a = pattern_vec(32'hA500_0000);
    c = random_vec();
    dst_ready = 1'b1;
    launch(a);
    for (int k = 0; k <= 10; k++) begin
      checks++; if (dst_data !== word_of(a, k)) begin errors++; $display("FAIL mid_reset data k=%0d got=%h exp=%h", k, dst_data, word_of(a, k)); end
      if (k == 10) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL mid_reset valid got=%b exp=0", dst_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_reset done got=%b exp=0", done); end
    checks++; if (dst_data !== 32'h0) begin errors++; $display("FAIL mid_reset data_clear got=%h exp=0", dst_data); end
    checks++; if (dst_last !== 1'b0) begin errors++; $display("FAIL mid_reset last got=%b exp=0", dst_last); end
    launch(c);
    for (int k = 0; k < NW; k++) begin
      checks++; if (dst_data !== word_of(c, k)) begin errors++; $display("FAIL restart data k=%0d got=%h exp=%h", k, dst_data, word_of(c, k)); end
      tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart done got=%b exp=1", done); end
    tick();
  endtask

  task automatic test_random();
    logic [DIM:0] v;
    int k, cyc;
    logic exp_ovr, fin, stray;
    for (int n = 0; n < 8; n++) begin
      v = random_vec();
      dst_ready = 1'b1;
      launch(v);
      k = 0; cyc = 0; exp_ovr = 1'b0;
      while (k < NW && cyc < 1000) begin
        checks++; if (dst_valid !== 1'b1) begin errors++; $display("FAIL random valid n=%0d cyc=%0d got=%b exp=1", n, cyc, dst_valid); end
        checks++; if (dst_data !== word_of(v, k)) begin errors++; $display("FAIL random data n=%0d k=%0d got=%h exp=%h", n, k, dst_data, word_of(v, k)); end
        checks++; if (dst_last !== (k == NW - 1)) begin errors++; $display("FAIL random last n=%0d k=%0d got=%b exp=%b", n, k, dst_last, (k == NW - 1)); end
        checks++; if (overrun !== exp_ovr) begin errors++; $display("FAIL random overrun n=%0d cyc=%0d got=%b exp=%b", n, cyc, overrun, exp_ovr); end
        dst_ready = ($urandom_range(0, 3) != 0);
        fin = dst_ready && (k == NW - 1);
        stray = !fin && ($urandom_range(0, 7) == 0);
        start = stray;
        if (stray) sign_bit = random_vec();
        exp_ovr = stray;
        if (dst_valid && dst_ready) k++;
        cyc++;
        tick();
      end
      start = 1'b0;
      checks++; if (k !== NW) begin errors++; $display("FAIL random timeout n=%0d beats=%0d exp=%0d", n, k, NW); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL random done n=%0d got=%b exp=1", n, done); end
      checks++; if (overrun !== exp_ovr) begin errors++; $display("FAIL random last_overrun n=%0d got=%b exp=%b", n, overrun, exp_ovr); end
      checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL random idle n=%0d got=%b exp=0", n, dst_valid); end
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; dst_ready = 1'b0; sign_bit = '0;
    test_reset();
    test_full_rate();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hv_stream_out.md
# hv_stream_out

Output serializer directly downstream of the per-dimension majority counters. On a `start` pulse it snapshots the full (DIM+1)-bit binarized hypervector `sign_bit` and emits it as 32-bit words on an AXI-Stream-style master port with valid/ready backpressure and a last-beat marker. It replaces the free-running `stream_v`/`stream_i` word select with a proper handshake toward the DMA.

## Interface

Parameters:
- `DIM`, default 1023: hypervector MSB index; vector width is DIM+1. (DIM+1) must be a multiple of 32; elaboration fails otherwise.
- `NWORDS`, derived (DIM+1)/32 (default 32): beats per vector.

Ports:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `sign_bit`  in  DIM+1  binarized hypervector from the counter array; sampled only on accepted `start`.
- `start`  in  1  single-cycle request to snapshot and send `sign_bit`.
- `dst_valid`  out  1  beat valid.
- `dst_ready`  in  1  sink ready.
- `dst_data`  out  32  beat payload.
- `dst_last`  out  1  high on final beat (word NWORDS-1).
- `busy`  out  1  high while a vector is in flight.
- `done`  out  1  one-cycle pulse after the final beat's handshake.
- `overrun`  out  1  one-cycle pulse when `start` is rejected.

## Operation

- States: IDLE, SEND.
- Accept conditions for `start`:
  - In IDLE, `start` is accepted.
  - In SEND, `start` is accepted only in the cycle of the final-beat handshake (valid & ready & last).
  - `start` in any other SEND cycle is ignored and pulses `overrun` next cycle; the current stream is unaffected.
- On accept: copy `sign_bit` into the shadow register, set index to 0, go or stay in SEND.
- SEND:
  - `dst_valid` = 1.
  - `dst_data` = shadow[32k+31:32k] for current index k.
  - `dst_last` = (k == NWORDS-1).
- Handshake = `dst_valid & dst_ready`.
  - On a non-final handshake: k increments.
  - On the final handshake without a simultaneous accepted start: go to IDLE.
- Data, last and index are held stable while `dst_valid & !dst_ready`.
- `busy` = (state == SEND).
- Index counter width is clog2(NWORDS). It never wraps; it is reloaded to 0 only by an accepted start.
- `rst` in any state, including mid-stream, takes effect at the next edge:
  - state returns to IDLE;
  - all outputs go to 0;
  - the shadow register is not cleared.

## Timing

- Reset values: `dst_valid` 0, `dst_data` 0, `dst_last` 0, `busy` 0, `done` 0, `overrun` 0.
- `start` accepted at cycle t → `dst_valid` = 1 at t+1 with word 0 of `sign_bit` as sampled at t.
- With `dst_ready` held high: one beat per cycle; word k appears at t+1+k; final beat at t+NWORDS.
- `done` = 1 exactly one cycle after the final handshake, for one cycle.
- Back-to-back `start` in the final-handshake cycle: word 0 of the new vector appears the next cycle with no bubble; `done` still pulses that cycle.
- `sign_bit` changes after the snapshot cycle have no effect on the stream.
- All outputs are registered; there is no combinational path from `dst_ready` to `dst_valid` or `dst_data`.

## Structure

- Shared package `hpu_pkg`:
  - `WORD_W` = 32;
  - `hv_out_state_t` enum {IDLE, SEND};
  - function computing NWORDS from DIM.
- Single module; no sub-module. The shadow register plus word mux is small enough to remain inline.

## Test plan

1. Assert `rst` for 2 cycles → all outputs 0; `busy` 0; no beats.
2. DIM=1023, word k of `sign_bit` = 0xA5000000|k, `start` at t, `dst_ready`=1 → 32 beats at t+1..t+32 with data 0xA5000000..0xA500001F; `dst_last` only on the last beat; `done` at t+33.
3. Same vector, `dst_ready` alternating 1,0 starting at 1 → 32 beats over 63 cycles; data and last stable during every stall; `done` one cycle after beat 31.
4. `start` pulsed at beat 5 with a different vector → `overrun` pulse next cycle; original 32 words delivered unchanged; no extra beats.
5. Second `start` in the final-handshake cycle with vector pattern 0x5A000000|k → beat 0x5A000000 in the immediately following cycle; `done` pulses in that same cycle; `busy` stays 1.
6. `rst` asserted at beat 10 → next cycle `dst_valid`=0, `busy`=0, `done`=0; a subsequent `start` restarts from word 0.
